// File: rtl/b2_mux_3_1_rr_arbiter_pkg.sv
// Shared definitions for the 2-bit 3:1 mux round-robin arbiter.
//   - state_e      : arbiter FSM state encoding (IDLE / GRANT)
//   - SEL_D*       : mux select codes for the three data words
//   - IDLE_SEL_DEF : default select code driven while no grant is active
//   - DATA_W       : width of each requester data word
//   - onehot3()    : select index to one-hot grant vector
package mux_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int          DATA_W       = 2;
  localparam logic [1:0]  SEL_D0       = 2'b00;
  localparam logic [1:0]  SEL_D1       = 2'b01;
  localparam logic [1:0]  SEL_D2       = 2'b10;
  localparam logic [1:0]  IDLE_SEL_DEF = 2'b11;

  // Index 3 has no requester, so it maps to an empty grant.
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] oh;
    oh = 3'b000;
    case (idx)
      SEL_D0:  oh = 3'b001;
      SEL_D1:  oh = 3'b010;
      SEL_D2:  oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/b2_mux_3_1_rr_arbiter_if.sv
// Bus bundle between the requesters and the round-robin mux arbiter.
//   req      : requester i wants the mux (level)
//   d0/d1/d2 : data words of requesters 0/1/2
//   gnt      : one-hot registered grant, zero when idle
//   sel      : registered mux select (owner index or idle code)
//   y        : registered mux output
//   y_valid  : y holds data of a granted cycle
//   busy     : arbiter is in GRANT
// The master modport is the requester side, slave is the arbiter.
interface b2_mux_3_1_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [2:0]        req;
  logic [DATA_W-1:0] d0;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] d2;
  logic [2:0]        gnt;
  logic [1:0]        sel;
  logic [DATA_W-1:0] y;
  logic              y_valid;
  logic              busy;

  modport master (
    output req, d0, d1, d2,
    input  gnt, sel, y, y_valid, busy
  );

  modport slave (
    input  req, d0, d1, d2,
    output gnt, sel, y, y_valid, busy
  );

endinterface

// File: rtl/b2_mux_3_1_correct.sv
// Combinational 2-bit 3:1 mux used as the select datapath of the arbiter.
//   d0_i/d1_i/d2_i : data inputs
//   sel_i          : 00 -> d0, 01 -> d1, 10 -> d2, 11 -> zero
//   y_o            : selected word
module b2_mux_3_1_correct
  import mux_arb_pkg::*;
(
  input  logic [DATA_W-1:0] d0_i,
  input  logic [DATA_W-1:0] d1_i,
  input  logic [DATA_W-1:0] d2_i,
  input  logic [1:0]        sel_i,
  output logic [DATA_W-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (sel_i)
      SEL_D0:  y_o = d0_i;
      SEL_D1:  y_o = d1_i;
      SEL_D2:  y_o = d2_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/b2_mux_3_1_rr_arbiter.sv
// Round-robin arbiter and sequencer for the shared 2-bit 3:1 mux.
// Three requesters compete; one is granted at a time for at most MAX_HOLD
// consecutive cycles, the mux select follows the owner, and the selected
// word is registered as y together with a valid strobe.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of the arbiter bus (req, d0..d2 in; gnt, sel, y,
//            y_valid, busy out)
// Parameters:
//   MAX_HOLD : max consecutive grant cycles per tenure (1..15)
//   IDLE_SEL : select code driven while no grant is active
module b2_mux_3_1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int         MAX_HOLD = 4,
  parameter logic [1:0] IDLE_SEL = IDLE_SEL_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  b2_mux_3_1_rr_arbiter_if.slave  bus
);

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  // Round-robin search: last+1, last+2, last (mod 3). Result is
  // {found, index}; the previous owner is considered last so it only
  // wins again when nobody else is asking.
  function automatic logic [2:0] rr_pick(input logic [2:0] r,
                                         input logic [1:0] last);
    logic       found;
    logic [1:0] idx;
    int         cand;
    found = 1'b0;
    idx   = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      cand = (int'(last) + k) % 3;
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = 2'(cand);
      end
    end
    return {found, idx};
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [3:0]        hold_q, hold_d;
  logic [1:0]        last_q, last_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              y_valid_q, y_valid_d;

  logic [2:0]        pick_idle;
  logic [2:0]        pick_rel;
  logic              owner_keeps;
  logic [DATA_W-1:0] mux_y;

  // While in GRANT, sel_q is the owner index, so it doubles as the owner
  // register and as the "last" used for the re-pick at release.
  assign pick_idle   = rr_pick(bus.req, last_q);
  assign pick_rel    = rr_pick(bus.req, sel_q);
  assign owner_keeps = bus.req[sel_q] && (hold_q < MAX_HOLD_C);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_idle[2]) begin
          state_d = GRANT;
          sel_d   = pick_idle[1:0];
          gnt_d   = onehot3(pick_idle[1:0]);
          hold_d  = 4'd1;
        end
      end
      GRANT: begin
        if (owner_keeps) begin
          hold_d = hold_q + 4'd1;
        end else begin
          last_d = sel_q;
          if (pick_rel[2]) begin
            // Back-to-back handover, or re-grant of a lone requester.
            sel_d  = pick_rel[1:0];
            gnt_d  = onehot3(pick_rel[1:0]);
            hold_d = 4'd1;
          end else begin
            state_d = IDLE;
            sel_d   = IDLE_SEL;
            gnt_d   = 3'b000;
            hold_d  = 4'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = IDLE_SEL;
        gnt_d   = 3'b000;
        hold_d  = 4'd0;
      end
    endcase
  end

  b2_mux_3_1_correct u_mux (
    .d0_i  (bus.d0),
    .d1_i  (bus.d1),
    .d2_i  (bus.d2),
    .sel_i (sel_q),
    .y_o   (mux_y)
  );

  // y captures the word selected during a granted cycle, so it lags sel
  // by one cycle and simply holds while the arbiter is idle.
  assign y_d       = (state_q == GRANT) ? mux_y : y_q;
  assign y_valid_d = (state_q == GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= IDLE_SEL;
      gnt_q     <= 3'b000;
      hold_q    <= 4'd0;
      last_q    <= SEL_D2;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.busy    = (state_q == GRANT);

endmodule

// File: tb/tb_b2_mux_3_1_rr_arbiter.sv
module tb_b2_mux_3_1_rr_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  b2_mux_3_1_rr_arbiter_if bus ();

  b2_mux_3_1_rr_arbiter #(
    .MAX_HOLD (4),
    .IDLE_SEL (2'b11)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gnt"},     8'(bus.gnt),     8'h0);
    chk({tag, "_sel"},     8'(bus.sel),     8'h3);
    chk({tag, "_y"},       8'(bus.y),       8'h0);
    chk({tag, "_y_valid"}, 8'(bus.y_valid), 8'h0);
    chk({tag, "_busy"},    8'(bus.busy),    8'h0);
  endtask

  // Data words used throughout: d0=01, d1=11, d2=10.
  function automatic logic [1:0] dval(input int idx);
    case (idx)
      0:       return 2'b01;
      1:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  initial begin
    int own;
    int prev_own;
    total   = 0;
    bad     = 0;
    rst_n   = 1'b1;
    bus.req = 3'b000;
    bus.d0  = 2'b01;
    bus.d1  = 2'b11;
    bus.d2  = 2'b10;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1 chk_reset("reset");
    #9 rst_n = 1'b1;

    // Test 1: single requester 0.
    bus.req = 3'b001;
    step();
    chk("t1_gnt",  8'(bus.gnt),  8'h1);
    chk("t1_sel",  8'(bus.sel),  8'h0);
    chk("t1_busy", 8'(bus.busy), 8'h1);
    chk("t1_yv0",  8'(bus.y_valid), 8'h0);
    step();
    chk("t1_y",    8'(bus.y),       8'h1);
    chk("t1_yv1",  8'(bus.y_valid), 8'h1);

    bus.req = 3'b000;
    step();
    chk("t1_idle_gnt",  8'(bus.gnt),  8'h0);
    chk("t1_idle_sel",  8'(bus.sel),  8'h3);
    chk("t1_idle_busy", 8'(bus.busy), 8'h0);
    step();
    chk("t1_idle_yv", 8'(bus.y_valid), 8'h0);
    chk("t1_idle_y",  8'(bus.y),       8'h1);

    // Reset again so last=2 and rotation starts with requester 0.
    #2 rst_n = 1'b0;
    #1 chk("rst2_y", 8'(bus.y), 8'h0);
    #2 rst_n = 1'b1;

    // Test 2: all request, grants rotate 0,1,2,0 for 4 cycles each.
    bus.req  = 3'b111;
    prev_own = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      own = ((k - 1) / 4) % 3;
      chk($sformatf("t2_sel_%0d", k), 8'(bus.sel), 8'(own));
      chk($sformatf("t2_gnt_%0d", k), 8'(bus.gnt), 8'(1 << own));
      chk($sformatf("t2_busy_%0d", k), 8'(bus.busy), 8'h1);
      if (k >= 2) begin
        chk($sformatf("t2_y_%0d", k),  8'(bus.y),       8'(dval(prev_own)));
        chk($sformatf("t2_yv_%0d", k), 8'(bus.y_valid), 8'h1);
      end
      prev_own = own;
    end

    // Test 3: only requester 1, re-granted after each expiry.
    bus.req = 3'b010;
    for (int k = 17; k <= 26; k++) begin
      step();
      chk($sformatf("t3_gnt_%0d", k), 8'(bus.gnt),     8'h2);
      chk($sformatf("t3_sel_%0d", k), 8'(bus.sel),     8'h1);
      chk($sformatf("t3_yv_%0d", k),  8'(bus.y_valid), 8'h1);
      chk($sformatf("t3_y_%0d", k),   8'(bus.y),
          8'((k == 17) ? dval(0) : dval(1)));
    end

    // Test 4: owner 0 drops after 2 cycles while requester 2 waits.
    bus.req = 3'b001;
    step();
    chk("t4_gnt_a", 8'(bus.gnt), 8'h1);
    bus.req = 3'b101;
    step();
    chk("t4_gnt_b", 8'(bus.gnt), 8'h1);
    bus.req = 3'b100;
    step();
    chk("t4_gnt_c", 8'(bus.gnt), 8'h4);
    chk("t4_sel_c", 8'(bus.sel), 8'h2);
    step();
    chk("t4_y", 8'(bus.y), 8'h2);

    // Test 5: all requests drop mid-tenure; y holds despite data changes.
    bus.req = 3'b000;
    step();
    chk("t5_gnt",  8'(bus.gnt),     8'h0);
    chk("t5_sel",  8'(bus.sel),     8'h3);
    chk("t5_busy", 8'(bus.busy),    8'h0);
    chk("t5_yv_a", 8'(bus.y_valid), 8'h1);
    bus.d0 = 2'b00;
    bus.d2 = 2'b01;
    step();
    chk("t5_yv_b", 8'(bus.y_valid), 8'h0);
    chk("t5_y",    8'(bus.y),       8'h2);
    bus.d0 = 2'b01;
    bus.d2 = 2'b10;

    // Test 6: reset pulsed between edges mid-tenure.
    bus.req = 3'b001;
    step();
    chk("t6_gnt_a", 8'(bus.gnt), 8'h1);
    step();
    chk("t6_y_a", 8'(bus.y), 8'h1);
    #2 rst_n = 1'b0;
    #1 chk_reset("t6_async");
    bus.req = 3'b110;
    #2 rst_n = 1'b1;
    step();
    chk("t6_gnt_b", 8'(bus.gnt), 8'h2);
    chk("t6_sel_b", 8'(bus.sel), 8'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
